// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: 2-flop synchronizer, one-hot debounce FSM, SCEN/MCEN/CCEN enables.
// Define BTN_AUTOREPEAT_EN to enable MCEN auto-repeat while the button is held.
module btn_debounce_pulse #(
    parameter int DB_COUNT  = 500000,
    parameter int REP_COUNT = 25000000
) (
    input  logic ClkPort,
    input  logic Reset,
    input  logic PB,
    output logic DPB,
    output logic SCEN,
    output logic MCEN,
    output logic CCEN
);

    localparam int CNT_W = 25;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_COUNT - 1);

    localparam int S_INI  = 0;
    localparam int S_WQ   = 1;
    localparam int S_SCEN = 2;
    localparam int S_CCR  = 3;
    localparam int S_MCEN = 4;
    localparam int S_WFCR = 5;

    localparam logic [5:0] ST_INI  = 6'b000001;
    localparam logic [5:0] ST_WQ   = 6'b000010;
    localparam logic [5:0] ST_SCEN = 6'b000100;
    localparam logic [5:0] ST_CCR  = 6'b001000;
    localparam logic [5:0] ST_MCEN = 6'b010000;
    localparam logic [5:0] ST_WFCR = 6'b100000;

    if (DB_COUNT < 2 || DB_COUNT >= (1 << CNT_W) ||
        REP_COUNT < 2 || REP_COUNT >= (1 << CNT_W)) begin : g_bad_param
        $error("btn_debounce_pulse: DB_COUNT/REP_COUNT out of range 2..2^25-1");
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REP_COUNT - 1);
`endif

    logic             pb_meta_q, pb_meta_d;
    logic             pb_s_q, pb_s_d;
    logic [5:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        pb_meta_d = PB;
        pb_s_d    = pb_meta_q;
    end

    // State register; the synchronizer is cleared with it so a held button restarts debounce.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            pb_meta_q <= 1'b0;
            pb_s_q    <= 1'b0;
            state_q   <= ST_INI;
            cnt_q     <= '0;
        end else begin
            pb_meta_q <= pb_meta_d;
            pb_s_q    <= pb_s_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (1'b1)
            state_q[S_INI]: begin
                if (pb_s_q) begin
                    state_d = ST_WQ;
                    cnt_d   = '0;
                end
            end
            state_q[S_WQ]: begin
                if (!pb_s_q) begin
                    state_d = ST_INI;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_SCEN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            state_q[S_SCEN]: begin
                state_d = ST_CCR;
                cnt_d   = '0;
            end
            state_q[S_CCR]: begin
                if (!pb_s_q) begin
                    state_d = ST_WFCR;
                    cnt_d   = '0;
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (cnt_q == REP_LAST) begin
                    state_d = ST_MCEN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            state_q[S_MCEN]: begin
                state_d = ST_CCR;
                cnt_d   = '0;
            end
            state_q[S_WFCR]: begin
                // A release bounce returns to CCR without issuing another SCEN.
                if (pb_s_q) begin
                    state_d = ST_CCR;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_INI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_INI;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        DPB  = state_q[S_SCEN] | state_q[S_CCR] | state_q[S_MCEN] | state_q[S_WFCR];
        CCEN = DPB;
        SCEN = state_q[S_SCEN];
        MCEN = state_q[S_SCEN] | state_q[S_MCEN];
    end

endmodule

// File: doc/btn_debounce_pulse.md
BTN_DEBOUNCE_PULSE -- requirements
Module: btn_debounce_pulse

Interface
- REQ-001 SHALL have parameter DB_COUNT, default 500000, debounce interval in clocks (5 ms at 100 MHz); legal range 2..2^25-1.
- REQ-002 SHALL have parameter REP_COUNT, default 25000000, auto-repeat interval in clocks (250 ms at 100 MHz); legal range 2..2^25-1.
- REQ-003 SHALL have port ClkPort, input, 1 bit: the single clock; all flops on its rising edge.
- REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
- REQ-005 SHALL have port PB, input, 1 bit: raw, bouncing, asynchronous push-button (e.g. BtnL Start, BtnR Ack).
- REQ-006 SHALL have port DPB, output, 1 bit: debounced button level.
- REQ-007 SHALL have port SCEN, output, 1 bit: single-clock enable, one pulse per debounced press.
- REQ-008 SHALL have port MCEN, output, 1 bit: multiple-clock enable, one pulse per press plus auto-repeat pulses while held.
- REQ-009 SHALL have port CCEN, output, 1 bit: continuous enable, equal to DPB.

Function
- REQ-010 PB SHALL pass through a 2-flop synchronizer; only its output PB_s drives the FSM.
- REQ-011 FSM SHALL be one-hot with states INI, WQ, SCEN_ST, CCR, MCEN_ST, WFCR; a single 25-bit counter cnt SHALL be shared by all states.
- REQ-012 INI: PB_s=1 -> WQ, cnt<=0; else stay.
- REQ-013 WQ: PB_s=0 -> INI (bounce rejected); else cnt<=cnt+1; PB_s=1 with cnt==DB_COUNT-1 -> SCEN_ST.
- REQ-014 SCEN_ST SHALL last exactly one cycle, set cnt<=0, then go to CCR unconditionally.
- REQ-015 CCR: PB_s=0 -> WFCR, cnt<=0; else cnt<=cnt+1; cnt==REP_COUNT-1 with PB_s=1 -> MCEN_ST (repeat path only per REQ-024).
- REQ-016 MCEN_ST SHALL last exactly one cycle, set cnt<=0, then go to CCR.
- REQ-017 WFCR: PB_s=1 -> CCR, cnt<=0 (release bounce rejected; no new SCEN); else cnt<=cnt+1; cnt==DB_COUNT-1 -> INI.
- REQ-018 Outputs SHALL be Moore-decoded from state only: DPB=CCEN=1 in SCEN_ST, CCR, MCEN_ST, WFCR; SCEN=1 only in SCEN_ST; MCEN=1 in SCEN_ST and MCEN_ST.
- REQ-019 First SCEN/MCEN pulse SHALL be high during the cycle following the (DB_COUNT+3)th rising edge counted from the first edge sampling PB=1, provided PB stays high throughout.
- REQ-020 SCEN and MCEN pulses SHALL each be exactly one clock wide and never back-to-back.
- REQ-021 DPB SHALL fall DB_COUNT+3 edges after the first edge sampling PB=0, provided PB stays low.
- REQ-022 cnt SHALL never exceed max(DB_COUNT, REP_COUNT)-1 and SHALL not wrap.

Reset
- REQ-023 Reset asserted at any time, including mid-press or mid-repeat, SHALL immediately force state INI, cnt=0, synchronizer flops=0, and all outputs 0; after release the FSM SHALL treat a still-held PB as a new press (full debounce before SCEN).

Configuration
- REQ-024 Macro BTN_AUTOREPEAT_EN: if defined, CCR->MCEN_ST auto-repeat per REQ-015 SHALL be present; if undefined, CCR SHALL neither count nor enter MCEN_ST, MCEN_ST SHALL be unreachable, and MCEN SHALL equal SCEN.

Verification (DB_COUNT=4, REP_COUNT=10)
- REQ-025 Clean press: PB 0->1 held 40 cycles -> SCEN high exactly one cycle after edge 7; DPB high from same cycle.
- REQ-026 Bounce: PB high 3 cycles, low 1, repeated 5 times -> SCEN, MCEN, DPB stay 0.
- REQ-027 Hold with BTN_AUTOREPEAT_EN: PB held 40 cycles -> MCEN pulses at first-press cycle then every 11 cycles; SCEN exactly once; without macro MCEN pulses once only.
- REQ-028 Release bounce: after press, PB low 2 cycles then high 1 then low -> no second SCEN; DPB falls only after 4 consecutive synchronized-low cycles.
- REQ-029 Reset mid-hold: assert Reset while in CCR with PB high -> all outputs 0 same cycle; release Reset with PB still high -> SCEN again after edge 7.
